// File: rtl/cmd_decoder.sv
// cmd_decoder: command front end between the UART receiver and the
// vector-write / processing stages.
//   First byte in IDLE selects the operation: 8'h01/8'h02 start a vector
//   write (VEC_LEN payload bytes forwarded), 8'h03..8'h08 start an exec op,
//   8'h00 is ignored, anything else raises a one-cycle cmd_error.
//   op is held until op_finished (WRITE) or exec_done (EXEC) returns to IDLE.
// Optional feature macro: CMD_TIMEOUT_EN
//   When defined, a WRITE that sees no byte for TIMEOUT_CYCLES cycles is
//   aborted with a one-cycle timeout pulse. When undefined, timeout is 0.
module cmd_decoder #(
  parameter int VEC_LEN        = 1024,
  parameter int TIMEOUT_CYCLES = 100_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_ready,
  input  logic       op_finished,
  input  logic       exec_done,
  output logic [7:0] op,
  output logic [7:0] data_out,
  output logic       received,
  output logic       busy,
  output logic       cmd_error,
  output logic       timeout
);

  // Elaboration-time sanity checks on the configuration.
  if (VEC_LEN < 1 || VEC_LEN > 2047) begin : g_bad_vec_len
    $error("cmd_decoder: VEC_LEN must fit the 11-bit byte counter");
  end
  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 134217728) begin : g_bad_timeout
    $error("cmd_decoder: TIMEOUT_CYCLES must fit the 27-bit idle counter");
  end

  localparam logic [10:0] VEC_LEN_C = 11'(VEC_LEN);

  localparam logic [7:0] OP_NOP      = 8'h00;
  localparam logic [7:0] OP_WRITE_A  = 8'h01;
  localparam logic [7:0] OP_WRITE_B  = 8'h02;
  localparam logic [7:0] OP_EXEC_LO  = 8'h03;
  localparam logic [7:0] OP_EXEC_HI  = 8'h08;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_EXEC  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  op_q, op_d;
  logic [7:0]  data_out_q, data_out_d;
  logic        received_q, received_d;
  logic        busy_q, busy_d;
  logic        cmd_error_q, cmd_error_d;
  logic [10:0] byte_cnt_q, byte_cnt_d;

  logic is_write_code;
  logic is_exec_code;

  assign is_write_code = (rx_data == OP_WRITE_A) || (rx_data == OP_WRITE_B);
  assign is_exec_code  = (rx_data >= OP_EXEC_LO) && (rx_data <= OP_EXEC_HI);

`ifdef CMD_TIMEOUT_EN
  localparam logic [26:0] TMO_LAST = 27'(TIMEOUT_CYCLES - 1);

  logic [26:0] tmo_cnt_q, tmo_cnt_d;
  logic        timeout_q, timeout_d;
`endif

  // Next-state and registered-output computation for the command FSM.
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    data_out_d  = data_out_q;
    received_d  = 1'b0;
    cmd_error_d = 1'b0;
    byte_cnt_d  = byte_cnt_q;
`ifdef CMD_TIMEOUT_EN
    tmo_cnt_d   = tmo_cnt_q;
    timeout_d   = 1'b0;
`endif

    case (state_q)
      ST_IDLE: begin
        op_d = OP_NOP;
        if (rx_ready) begin
          if (is_write_code) begin
            op_d       = rx_data;
            byte_cnt_d = '0;
            state_d    = ST_WRITE;
`ifdef CMD_TIMEOUT_EN
            tmo_cnt_d  = '0;
`endif
          end else if (is_exec_code) begin
            op_d    = rx_data;
            state_d = ST_EXEC;
          end else if (rx_data != OP_NOP) begin
            cmd_error_d = 1'b1;
          end
        end
      end

      ST_WRITE: begin
        // Completion wins over a byte arriving in the same cycle.
        if (op_finished) begin
          state_d = ST_IDLE;
          op_d    = OP_NOP;
        end else if (rx_ready) begin
          // Bytes beyond a full vector are dropped; the count saturates.
          if (byte_cnt_q < VEC_LEN_C) begin
            data_out_d = rx_data;
            received_d = 1'b1;
            byte_cnt_d = byte_cnt_q + 11'd1;
          end
`ifdef CMD_TIMEOUT_EN
          tmo_cnt_d = '0;
        end else if (tmo_cnt_q == TMO_LAST) begin
          timeout_d = 1'b1;
          state_d   = ST_IDLE;
          op_d      = OP_NOP;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 27'd1;
`endif
        end
      end

      ST_EXEC: begin
        // Payload bytes are meaningless during exec and are dropped.
        if (exec_done) begin
          state_d = ST_IDLE;
          op_d    = OP_NOP;
        end
      end

      default: begin
        state_d = ST_IDLE;
        op_d    = OP_NOP;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers; reset abandons any partial operation at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      op_q        <= '0;
      data_out_q  <= '0;
      received_q  <= 1'b0;
      busy_q      <= 1'b0;
      cmd_error_q <= 1'b0;
      byte_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      data_out_q  <= data_out_d;
      received_q  <= received_d;
      busy_q      <= busy_d;
      cmd_error_q <= cmd_error_d;
      byte_cnt_q  <= byte_cnt_d;
    end
  end

`ifdef CMD_TIMEOUT_EN
  // Idle-byte watchdog registers for WRITE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmo_cnt_q <= '0;
      timeout_q <= 1'b0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout = timeout_q;
`else
  assign timeout = 1'b0;
`endif

  assign op        = op_q;
  assign data_out  = data_out_q;
  assign received  = received_q;
  assign busy      = busy_q;
  assign cmd_error = cmd_error_q;

endmodule

// File: tb/tb_cmd_decoder.sv
// Testbench for cmd_decoder: table of single-cycle vectors plus hand-written
// multi-cycle sequences; forwarded bytes are checked through a queue.
module tb_cmd_decoder;

  logic       clk;
  logic       rst;
  logic [7:0] rx_data;
  logic       rx_ready;
  logic       op_finished;
  logic       exec_done;
  logic [7:0] op;
  logic [7:0] data_out;
  logic       received;
  logic       busy;
  logic       cmd_error;
  logic       timeout;

  int checks = 0;
  int errors = 0;
  int rcv_cnt = 0;
  logic [7:0] sb[$];

  cmd_decoder #(
    .VEC_LEN(1024),
    .TIMEOUT_CYCLES(50)
  ) dut (
    .clk(clk),
    .rst(rst),
    .rx_data(rx_data),
    .rx_ready(rx_ready),
    .op_finished(op_finished),
    .exec_done(exec_done),
    .op(op),
    .data_out(data_out),
    .received(received),
    .busy(busy),
    .cmd_error(cmd_error),
    .timeout(timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Scoreboard: every received pulse must match the oldest expected byte.
  always @(negedge clk) begin
    if (!rst && received) begin
      rcv_cnt++;
      if (sb.size() == 0) begin
        chk("unexpected_received", 32'(data_out), 32'hFFFF_FFFF);
      end else begin
        chk("data_out", 32'(data_out), 32'(sb.pop_front()));
      end
    end
  end

  task automatic cyc(input logic r, input logic [7:0] d, input logic f, input logic e);
    rx_ready    = r;
    rx_data     = d;
    op_finished = f;
    exec_done   = e;
    @(posedge clk);
    #1;
    rx_ready    = 1'b0;
    op_finished = 1'b0;
    exec_done   = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  // Send one payload byte; forward says whether a received pulse is due.
  task automatic send(input logic [7:0] d, input logic forward);
    if (forward) sb.push_back(d);
    cyc(1'b1, d, 1'b0, 1'b0);
  endtask

  typedef struct {
    logic       r;
    logic [7:0] d;
    logic       f;
    logic       e;
    logic [7:0] exp_op;
    logic       exp_busy;
    logic       exp_err;
    logic       exp_rcv;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t mk(input logic r, input logic [7:0] d, input logic f,
                              input logic e, input logic [7:0] o, input logic b,
                              input logic er, input logic rc);
    vec_t v;
    v.r = r; v.d = d; v.f = f; v.e = e;
    v.exp_op = o; v.exp_busy = b; v.exp_err = er; v.exp_rcv = rc;
    return v;
  endfunction

  initial begin
    int base;
    int k;
    logic seen;
    rx_data = 8'h00; rx_ready = 1'b0; op_finished = 1'b0; exec_done = 1'b0;
    rst = 1'b1;
    #12;
    chk("rst_op", 32'(op), 32'h0);
    chk("rst_data_out", 32'(data_out), 32'h0);
    chk("rst_received", 32'(received), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_cmd_error", 32'(cmd_error), 32'h0);
    chk("rst_timeout", 32'(timeout), 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    idle(2);

    //          r     d      f     e     op     busy  err   rcv
    vt.push_back(mk(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0));
    vt.push_back(mk(1'b1, 8'hFF, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0));
    vt.push_back(mk(1'b1, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0));
    vt.push_back(mk(1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0));
    vt.push_back(mk(1'b0, 8'h00, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0));
    vt.push_back(mk(1'b1, 8'h01, 1'b0, 1'b0, 8'h01, 1'b1, 1'b0, 1'b0));
    vt.push_back(mk(1'b1, 8'h11, 1'b0, 1'b0, 8'h01, 1'b1, 1'b0, 1'b1));
    vt.push_back(mk(1'b1, 8'h22, 1'b0, 1'b0, 8'h01, 1'b1, 1'b0, 1'b1));
    vt.push_back(mk(1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0));
    vt.push_back(mk(1'b1, 8'h33, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0));
    vt.push_back(mk(1'b1, 8'h05, 1'b0, 1'b0, 8'h05, 1'b1, 1'b0, 1'b0));
    vt.push_back(mk(1'b1, 8'hAA, 1'b0, 1'b0, 8'h05, 1'b1, 1'b0, 1'b0));
    vt.push_back(mk(1'b0, 8'h00, 1'b1, 1'b0, 8'h05, 1'b1, 1'b0, 1'b0));
    vt.push_back(mk(1'b1, 8'hBB, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0));
    vt.push_back(mk(1'b1, 8'h02, 1'b0, 1'b0, 8'h02, 1'b1, 1'b0, 1'b0));
    vt.push_back(mk(1'b1, 8'h44, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0));
    vt.push_back(mk(1'b1, 8'h03, 1'b0, 1'b0, 8'h03, 1'b1, 1'b0, 1'b0));
    vt.push_back(mk(1'b0, 8'h00, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0));
    vt.push_back(mk(1'b1, 8'h08, 1'b0, 1'b0, 8'h08, 1'b1, 1'b0, 1'b0));
    vt.push_back(mk(1'b1, 8'h09, 1'b0, 1'b0, 8'h08, 1'b1, 1'b0, 1'b0));
    vt.push_back(mk(1'b0, 8'h00, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0));
    vt.push_back(mk(1'b1, 8'h09, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0));
    vt.push_back(mk(1'b1, 8'h01, 1'b0, 1'b0, 8'h01, 1'b1, 1'b0, 1'b0));
    vt.push_back(mk(1'b1, 8'h01, 1'b0, 1'b0, 8'h01, 1'b1, 1'b0, 1'b1));
    vt.push_back(mk(1'b0, 8'h00, 1'b0, 1'b1, 8'h01, 1'b1, 1'b0, 1'b0));
    vt.push_back(mk(1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0));

    for (int i = 0; i < vt.size(); i++) begin
      if (vt[i].exp_rcv) sb.push_back(vt[i].d);
      cyc(vt[i].r, vt[i].d, vt[i].f, vt[i].e);
      chk($sformatf("vec%0d_op", i), 32'(op), 32'(vt[i].exp_op));
      chk($sformatf("vec%0d_busy", i), 32'(busy), 32'(vt[i].exp_busy));
      chk($sformatf("vec%0d_cmd_error", i), 32'(cmd_error), 32'(vt[i].exp_err));
      chk($sformatf("vec%0d_received", i), 32'(received), 32'(vt[i].exp_rcv));
    end
    idle(1);
    chk("vec_sb_empty", 32'(sb.size()), 32'h0);

    // writeVec_A: full vector with occasional gaps.
    cyc(1'b1, 8'h01, 1'b0, 1'b0);
    chk("wa_op", 32'(op), 32'h01);
    base = rcv_cnt;
    for (int i = 0; i < 1024; i++) begin
      send(8'(i) ^ 8'h5A, 1'b1);
      if (i == 100) begin
        idle(1);
        chk("wa_hold_data_out", 32'(data_out), 32'(8'(i) ^ 8'h5A));
        chk("wa_hold_received", 32'(received), 32'h0);
      end
    end
    idle(2);
    chk("wa_count", 32'(rcv_cnt - base), 32'd1024);
    chk("wa_sb_empty", 32'(sb.size()), 32'h0);
    chk("wa_op_held", 32'(op), 32'h01);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    chk("wa_done_op", 32'(op), 32'h0);
    chk("wa_done_busy", 32'(busy), 32'h0);

    // writeVec_B: overrun by six bytes.
    cyc(1'b1, 8'h02, 1'b0, 1'b0);
    chk("wb_op", 32'(op), 32'h02);
    base = rcv_cnt;
    for (int i = 0; i < 1030; i++) send(8'(i * 3), i < 1024);
    idle(2);
    chk("wb_count", 32'(rcv_cnt - base), 32'd1024);
    chk("wb_sb_empty", 32'(sb.size()), 32'h0);
    chk("wb_busy", 32'(busy), 32'h1);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    chk("wb_done_op", 32'(op), 32'h0);

    // Reset in the middle of a vector, then a fresh full vector.
    cyc(1'b1, 8'h01, 1'b0, 1'b0);
    for (int i = 0; i < 500; i++) send(8'(i + 7), 1'b1);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_op", 32'(op), 32'h0);
    chk("mid_rst_data_out", 32'(data_out), 32'h0);
    chk("mid_rst_received", 32'(received), 32'h0);
    chk("mid_rst_busy", 32'(busy), 32'h0);
    sb.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    idle(1);
    cyc(1'b1, 8'h01, 1'b0, 1'b0);
    chk("rr_op", 32'(op), 32'h01);
    base = rcv_cnt;
    for (int i = 0; i < 1024; i++) send(8'(i + 1), 1'b1);
    idle(2);
    chk("rr_count", 32'(rcv_cnt - base), 32'd1024);
    chk("rr_sb_empty", 32'(sb.size()), 32'h0);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    chk("rr_done_op", 32'(op), 32'h0);

    // WRITE with silence after three bytes.
    cyc(1'b1, 8'h01, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) send(8'hC0 + 8'(i), 1'b1);
`ifdef CMD_TIMEOUT_EN
    k = 0;
    seen = 1'b0;
    while (!seen && k < 200) begin
      idle(1);
      k++;
      seen = timeout;
    end
    chk("tmo_seen", 32'(seen), 32'h1);
    chk("tmo_cycles", 32'(k), 32'd50);
    chk("tmo_op", 32'(op), 32'h0);
    chk("tmo_busy", 32'(busy), 32'h0);
    idle(1);
    chk("tmo_pulse_len", 32'(timeout), 32'h0);
`else
    seen = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      idle(1);
      if (timeout) seen = 1'b1;
    end
    chk("notmo_never", 32'(seen), 32'h0);
    chk("notmo_op", 32'(op), 32'h01);
    chk("notmo_busy", 32'(busy), 32'h1);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    chk("notmo_done_op", 32'(op), 32'h0);
    k = 0;
`endif
    idle(2);
    chk("final_sb_empty", 32'(sb.size()), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
